inst_decode_stage: RTL and testbench

- Registered, parametrised instruction-decode stage for the MIPS datapath. Sits between instruction fetch and register file/ALU control.
- Splits the instruction into fields and sign- or zero-extends the immediate to the datapath width.
- Computes branch and jump targets and classifies the instruction.
- Holds one entry behind a valid/ready handshake, with stall and flush, so the core can move to a pipelined organisation.

---
 rtl/mips_pkg.sv | 39 +++
 rtl/inst_decode_stage_if.sv | 41 ++++
 rtl/inst_field_decode.sv | 81 ++++++++
 rtl/inst_decode_stage.sv | 120 ++++++++++++
 tb/tb_inst_decode_stage.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS encodings: opcode/funct values and the decode-stage instruction classes.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    CLS_R_ALU   = 3'd0,
    CLS_I_ARITH = 3'd1,
    CLS_I_LOGIC = 3'd2,
    CLS_LOAD    = 3'd3,
    CLS_STORE   = 3'd4,
    CLS_BRANCH  = 3'd5,
    CLS_JUMP    = 3'd6,
    CLS_ILLEGAL = 3'd7
  } inst_class_e;

  function automatic logic is_supported_funct(input logic [5:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_ADD) || (fn == FN_SUB) ||
           (fn == FN_AND) || (fn == FN_OR)  || (fn == FN_SLT);
  endfunction

endpackage

// File: rtl/inst_decode_stage_if.sv
// Fetch-side and decoded-side buses of the decode stage.
// Handshake: a beat moves on a rising edge where valid && ready; the master holds
// valid and its payload stable until then, and ready may depend combinationally on state.
interface inst_decode_stage_fetch_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     inst;
  logic [PC_W-1:0] pc_plus4;

  modport master (output in_valid, inst, pc_plus4, input in_ready);
  modport slave  (input in_valid, inst, pc_plus4, output in_ready);
endinterface

interface inst_decode_stage_dec_if #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
);
  logic              out_valid;
  logic              out_ready;
  logic [5:0]        opcode;
  logic [5:0]        funct;
  logic [4:0]        shamt;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic [DATA_W-1:0] imm_ext;
  logic [PC_W-1:0]   jump_target;
  logic [PC_W-1:0]   branch_target;
  logic [2:0]        inst_class;
  logic              illegal;

  modport master (output out_valid, opcode, funct, shamt, rs, rt, rd, imm_ext,
                  jump_target, branch_target, inst_class, illegal,
                  input out_ready);
  modport slave  (input out_valid, opcode, funct, shamt, rs, rt, rd, imm_ext,
                  jump_target, branch_target, inst_class, illegal,
                  output out_ready);
endinterface

// File: rtl/inst_field_decode.sv
// Combinational field split, immediate extension, target computation and classification.
module inst_field_decode
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5
) (
  input  logic [31:0]       i_inst,
  input  logic [PC_W-1:0]   i_pc_plus4,
  output logic [5:0]        o_opcode,
  output logic [5:0]        o_funct,
  output logic [4:0]        o_shamt,
  output logic [REG_AW-1:0] o_rs,
  output logic [REG_AW-1:0] o_rt,
  output logic [REG_AW-1:0] o_rd,
  output logic [DATA_W-1:0] o_imm_ext,
  output logic [PC_W-1:0]   o_jump_target,
  output logic [PC_W-1:0]   o_branch_target,
  output inst_class_e       o_inst_class
);

  logic [DATA_W-1:0] w_imm_sext;
  logic [DATA_W-1:0] w_imm_zext;
  logic [PC_W-1:0]   w_branch_off;

  assign w_imm_sext   = {{(DATA_W-16){i_inst[15]}}, i_inst[15:0]};
  assign w_imm_zext   = {{(DATA_W-16){1'b0}}, i_inst[15:0]};
  assign w_branch_off = {{(PC_W-18){i_inst[15]}}, i_inst[15:0], 2'b00};

  always_comb begin : p_decode
    logic w_rstyle;
    logic w_itype;
    w_rstyle        = 1'b0;
    w_itype         = 1'b0;
    o_opcode        = i_inst[31:26];
    o_funct         = '0;
    o_shamt         = '0;
    o_rs            = '0;
    o_rt            = '0;
    o_rd            = '0;
    o_imm_ext       = '0;
    o_inst_class    = CLS_ILLEGAL;
    o_jump_target   = i_pc_plus4;
    o_jump_target[27:0] = {i_inst[25:0], 2'b00};
    o_branch_target = i_pc_plus4 + w_branch_off;

    case (i_inst[31:26])
      OP_RTYPE: begin
        w_rstyle = 1'b1;
        if (is_supported_funct(i_inst[5:0])) o_inst_class = CLS_R_ALU;
      end
      OP_ADDI: begin w_itype = 1'b1; o_imm_ext = w_imm_sext; o_inst_class = CLS_I_ARITH; end
      OP_ANDI,
      OP_ORI:  begin w_itype = 1'b1; o_imm_ext = w_imm_zext; o_inst_class = CLS_I_LOGIC; end
      OP_LW:   begin w_itype = 1'b1; o_imm_ext = w_imm_sext; o_inst_class = CLS_LOAD;    end
      OP_SW:   begin w_itype = 1'b1; o_imm_ext = w_imm_sext; o_inst_class = CLS_STORE;   end
      OP_BEQ,
      OP_BNE:  begin w_itype = 1'b1; o_imm_ext = w_imm_sext; o_inst_class = CLS_BRANCH;  end
      OP_J:    o_inst_class = CLS_JUMP;
      OP_JAL:  begin o_inst_class = CLS_JUMP; o_rd = REG_AW'(5'd31); end
      default: w_rstyle = 1'b1;
    endcase

    if (w_itype) begin
      o_rs = REG_AW'(i_inst[25:21]);
      o_rt = REG_AW'(i_inst[20:16]);
    end
    // Unsupported encodings still expose R-style fields for debug/trap handling.
    if (w_rstyle) begin
      o_rs    = REG_AW'(i_inst[25:21]);
      o_rt    = REG_AW'(i_inst[20:16]);
      o_rd    = REG_AW'(i_inst[15:11]);
      o_shamt = i_inst[10:6];
      o_funct = i_inst[5:0];
      if (i_inst[31:26] == OP_RTYPE && (i_inst[5:0] == FN_SLL || i_inst[5:0] == FN_SRL))
        o_rs = '0;
    end
  end

endmodule

// File: rtl/inst_decode_stage.sv
// Registered decode stage: one-entry valid/ready buffer with flush, fed by inst_field_decode.
module inst_decode_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int PC_W   = 32,
  parameter int REG_AW = 5,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  inst_decode_stage_fetch_if.slave fetch,
  inst_decode_stage_dec_if.master  dec,
  output logic [CNT_W-1:0]     dec_count
);

  if (DATA_W < 32) begin : g_bad_data_w
    $error("DATA_W must be >= 32");
  end
  if (PC_W < 28) begin : g_bad_pc_w
    $error("PC_W must be >= 28");
  end
  if (REG_AW < 5) begin : g_bad_reg_aw
    $error("REG_AW must be >= 5");
  end

  logic [5:0]        w_opcode, w_funct;
  logic [4:0]        w_shamt;
  logic [REG_AW-1:0] w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_imm_ext;
  logic [PC_W-1:0]   w_jump_target, w_branch_target;
  inst_class_e       w_inst_class;
  logic              w_in_ready, w_capture, w_drain;

  logic              r_valid;
  logic [5:0]        r_opcode, r_funct;
  logic [4:0]        r_shamt;
  logic [REG_AW-1:0] r_rs, r_rt, r_rd;
  logic [DATA_W-1:0] r_imm_ext;
  logic [PC_W-1:0]   r_jump_target, r_branch_target;
  inst_class_e       r_inst_class;
  logic [CNT_W-1:0]  r_count;

  inst_field_decode #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .REG_AW (REG_AW)
  ) u_field_decode (
    .i_inst          (fetch.inst),
    .i_pc_plus4      (fetch.pc_plus4),
    .o_opcode        (w_opcode),
    .o_funct         (w_funct),
    .o_shamt         (w_shamt),
    .o_rs            (w_rs),
    .o_rt            (w_rt),
    .o_rd            (w_rd),
    .o_imm_ext       (w_imm_ext),
    .o_jump_target   (w_jump_target),
    .o_branch_target (w_branch_target),
    .o_inst_class    (w_inst_class)
  );

  // Drain and capture may happen in the same cycle for full throughput.
  assign w_in_ready = !r_valid || dec.out_ready;
  assign w_capture  = fetch.in_valid && w_in_ready && !flush;
  assign w_drain    = r_valid && dec.out_ready && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid         <= 1'b0;
      r_opcode        <= '0;
      r_funct         <= '0;
      r_shamt         <= '0;
      r_rs            <= '0;
      r_rt            <= '0;
      r_rd            <= '0;
      r_imm_ext       <= '0;
      r_jump_target   <= '0;
      r_branch_target <= '0;
      r_inst_class    <= CLS_R_ALU;
      r_count         <= '0;
    end else begin
      if (flush)          r_valid <= 1'b0;
      else if (w_capture) r_valid <= 1'b1;
      else if (w_drain)   r_valid <= 1'b0;

      if (w_capture) begin
        r_opcode        <= w_opcode;
        r_funct         <= w_funct;
        r_shamt         <= w_shamt;
        r_rs            <= w_rs;
        r_rt            <= w_rt;
        r_rd            <= w_rd;
        r_imm_ext       <= w_imm_ext;
        r_jump_target   <= w_jump_target;
        r_branch_target <= w_branch_target;
        r_inst_class    <= w_inst_class;
      end

      if (w_drain) r_count <= r_count + 1'b1;
    end
  end

  assign fetch.in_ready    = w_in_ready;
  assign dec.out_valid     = r_valid;
  assign dec.opcode        = r_opcode;
  assign dec.funct         = r_funct;
  assign dec.shamt         = r_shamt;
  assign dec.rs            = r_rs;
  assign dec.rt            = r_rt;
  assign dec.rd            = r_rd;
  assign dec.imm_ext       = r_imm_ext;
  assign dec.jump_target   = r_jump_target;
  assign dec.branch_target = r_branch_target;
  assign dec.inst_class    = r_inst_class;
  assign dec.illegal       = (r_inst_class == CLS_ILLEGAL);
  assign dec_count         = r_count;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Bench for inst_decode_stage: directed vector table, stall/flush/reset sequences,
// a DATA_W=64 instance, and a randomized run against a behavioural decode model.
module tb_inst_decode_stage;

  typedef struct packed {
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [31:0] jt;
    logic [31:0] bt;
    logic [2:0]  cls;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    exp_t        e;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  logic flush64 = 1'b0;
  always #5 clk = ~clk;

  inst_decode_stage_fetch_if #(.PC_W(32)) fin ();
  inst_decode_stage_dec_if #(.DATA_W(32), .PC_W(32), .REG_AW(5)) dout ();
  logic [15:0] dec_count;

  inst_decode_stage #(.DATA_W(32), .PC_W(32), .REG_AW(5), .CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .fetch     (fin),
    .dec       (dout),
    .dec_count (dec_count)
  );

  inst_decode_stage_fetch_if #(.PC_W(32)) fin64 ();
  inst_decode_stage_dec_if #(.DATA_W(64), .PC_W(32), .REG_AW(5)) dout64 ();
  logic [15:0] dec_count64;

  inst_decode_stage #(.DATA_W(64), .PC_W(32), .REG_AW(5), .CNT_W(16)) u_dut64 (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush64),
    .fetch     (fin64),
    .dec       (dout64),
    .dec_count (dec_count64)
  );

  // scoreboard state
  int          total = 0;
  int          bad = 0;
  logic [15:0] exp_cnt = '0;
  exp_t        exp_q[$];
  vec_t        vecs[14];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input exp_t e);
    chk({tag, ".opcode"}, 64'(dout.opcode), 64'(e.opcode));
    chk({tag, ".funct"},  64'(dout.funct),  64'(e.funct));
    chk({tag, ".shamt"},  64'(dout.shamt),  64'(e.shamt));
    chk({tag, ".rs"},     64'(dout.rs),     64'(e.rs));
    chk({tag, ".rt"},     64'(dout.rt),     64'(e.rt));
    chk({tag, ".rd"},     64'(dout.rd),     64'(e.rd));
    chk({tag, ".imm"},    64'(dout.imm_ext), 64'(e.imm));
    chk({tag, ".jt"},     64'(dout.jump_target), 64'(e.jt));
    chk({tag, ".bt"},     64'(dout.branch_target), 64'(e.bt));
    chk({tag, ".class"},  64'(dout.inst_class), 64'(e.cls));
    chk({tag, ".illegal"}, 64'(dout.illegal), 64'(e.ill));
  endtask

  function automatic vec_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input int op, input int fn, input int sh,
                              input int rs, input int rt, input int rd,
                              input logic [31:0] imm, input logic [31:0] jt,
                              input logic [31:0] bt, input int cls, input int ill);
    vec_t v;
    v.inst = inst;
    v.pc   = pc;
    v.e    = '{opcode: 6'(op), funct: 6'(fn), shamt: 5'(sh), rs: 5'(rs), rt: 5'(rt),
               rd: 5'(rd), imm: imm, jt: jt, bt: bt, cls: 3'(cls), ill: 1'(ill)};
    return v;
  endfunction

  // Behavioural model: decode rules written as plain arithmetic on the instruction word.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   op, fn, simm;
    bit   rstyle;
    op     = int'(ins >> 26);
    fn     = int'(ins % 64);
    simm   = int'($signed(ins[15:0]));
    e      = '0;
    rstyle = 1'b0;
    e.opcode = 6'(op);
    e.jt   = (pc & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) * 4);
    e.bt   = pc + 32'(simm * 4);
    case (op)
      0:       begin rstyle = 1'b1; e.cls = (fn inside {0, 2, 32, 34, 36, 37, 42}) ? 3'd0 : 3'd7; end
      8:       e.cls = 3'd1;
      12, 13:  e.cls = 3'd2;
      35:      e.cls = 3'd3;
      43:      e.cls = 3'd4;
      4, 5:    e.cls = 3'd5;
      2, 3:    e.cls = 3'd6;
      default: begin rstyle = 1'b1; e.cls = 3'd7; end
    endcase
    if (rstyle) begin
      e.rs    = 5'((ins >> 21) % 32);
      e.rt    = 5'((ins >> 16) % 32);
      e.rd    = 5'((ins >> 11) % 32);
      e.shamt = 5'((ins >> 6) % 32);
      e.funct = 6'(fn);
      if (op == 0 && (fn == 0 || fn == 2)) e.rs = '0;
    end else if (e.cls != 3'd6) begin
      e.rs  = 5'((ins >> 21) % 32);
      e.rt  = 5'((ins >> 16) % 32);
      e.imm = (e.cls == 3'd2) ? (ins % 65536) : 32'(simm);
    end else if (op == 3) begin
      e.rd = 5'd31;
    end
    e.ill = (e.cls == 3'd7);
    return e;
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    logic [5:0]  op, fn;
    r = $urandom();
    case ($urandom_range(0, 11))
      0, 1:    op = 6'd0;
      2:       op = 6'd8;
      3:       op = 6'd12;
      4:       op = 6'd13;
      5:       op = 6'd35;
      6:       op = 6'd43;
      7:       op = 6'd4;
      8:       op = 6'd5;
      9:       op = 6'd2;
      10:      op = 6'd3;
      default: op = 6'($urandom_range(0, 63));
    endcase
    case ($urandom_range(0, 7))
      0:       fn = 6'd0;
      1:       fn = 6'd2;
      2:       fn = 6'd32;
      3:       fn = 6'd34;
      4:       fn = 6'd36;
      5:       fn = 6'd37;
      6:       fn = 6'd42;
      default: fn = 6'($urandom_range(0, 63));
    endcase
    return {op, r[25:6], fn};
  endfunction

  // driver
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    fin.in_valid   = v;
    fin.inst       = ins;
    fin.pc_plus4   = pc;
    dout.out_ready = ordy;
    flush          = fl;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(32'h2128FFFC, 32'h0000_1000,  8,  0, 0, 9, 8,  0, 32'hFFFFFFFC, 32'h04A3FFF0, 32'h00000FF0, 1, 0);
    vecs[1]  = mk(32'h35288000, 32'h0000_2000, 13,  0, 0, 9, 8,  0, 32'h00008000, 32'h04A20000, 32'hFFFE2000, 2, 0);
    vecs[2]  = mk(32'h00094100, 32'h0000_3000,  0,  0, 4, 0, 9,  8, 32'h0,        32'h00250400, 32'h00013400, 0, 0);
    vecs[3]  = mk(32'h08100004, 32'h0040_0004,  2,  0, 0, 0, 0,  0, 32'h0,        32'h00400010, 32'h00400014, 6, 0);
    vecs[4]  = mk(32'h1128FFFF, 32'h0000_0100,  4,  0, 0, 9, 8,  0, 32'hFFFFFFFF, 32'h04A3FFFC, 32'h000000FC, 5, 0);
    vecs[5]  = mk(32'hFC000000, 32'h0000_0000, 63,  0, 0, 0, 0,  0, 32'h0,        32'h0,        32'h0,        7, 1);
    vecs[6]  = mk(32'h0C000010, 32'h8000_0000,  3,  0, 0, 0, 0, 31, 32'h0,        32'h80000040, 32'h80000040, 6, 0);
    vecs[7]  = mk(32'h8C450008, 32'h0000_0010, 35,  0, 0, 2, 5,  0, 32'h00000008, 32'h01140020, 32'h00000030, 3, 0);
    vecs[8]  = mk(32'hAC45FFF8, 32'hFFFF_FFF0, 43,  0, 0, 2, 5,  0, 32'hFFFFFFF8, 32'hF117FFE0, 32'hFFFFFFD0, 4, 0);
    vecs[9]  = mk(32'h01095020, 32'h0000_0000,  0, 32, 0, 8, 9, 10, 32'h0,        32'h04254080, 32'h00014080, 0, 0);
    vecs[10] = mk(32'h01095021, 32'h0000_0000,  0, 33, 0, 8, 9, 10, 32'h0,        32'h04254084, 32'h00014084, 7, 1);
    vecs[11] = mk(32'h03E94082, 32'h0000_0000,  0,  2, 2, 0, 9,  8, 32'h0,        32'h0FA50208, 32'h00010208, 0, 0);
    vecs[12] = mk(32'h15280004, 32'h0000_0200,  5,  0, 0, 9, 8,  0, 32'h00000004, 32'h04A00010, 32'h00000210, 5, 0);
    vecs[13] = mk(32'h3128FFFF, 32'h0000_0000, 12,  0, 0, 9, 8,  0, 32'h0000FFFF, 32'h04A3FFFC, 32'hFFFFFFFC, 2, 0);

    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    fin64.in_valid = 1'b0;
    fin64.inst = '0;
    fin64.pc_plus4 = '0;
    dout64.out_ready = 1'b1;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("reset.out_valid", 64'(dout.out_valid), 64'd0);
    chk("reset.in_ready", 64'(fin.in_ready), 64'd1);
    chk("reset.dec_count", 64'(dec_count), 64'd0);
    check_out("reset", '0);
    @(negedge clk);
    reset = 1'b0;

    // vector table, back-to-back at full throughput
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      if (i < 14) drive(1'b1, vecs[i].inst, vecs[i].pc, 1'b1, 1'b0);
      else        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      #1;
      if (i > 0) begin
        chk($sformatf("vec%0d.out_valid", i - 1), 64'(dout.out_valid), 64'd1);
        chk($sformatf("vec%0d.in_ready", i - 1), 64'(fin.in_ready), 64'd1);
        chk($sformatf("vec%0d.dec_count", i - 1), 64'(dec_count), 64'(exp_cnt));
        check_out($sformatf("vec%0d", i - 1), vecs[i - 1].e);
        exp_cnt++;
      end
    end
    @(negedge clk);
    #1;
    chk("table.drained", 64'(dout.out_valid), 64'd0);
    chk("table.dec_count", 64'(dec_count), 64'(exp_cnt));

    // stall: downstream not ready for 3 cycles after capture
    drive(1'b1, vecs[0].inst, vecs[0].pc, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1, vecs[1].inst, vecs[1].pc, 1'b0, 1'b0);
      #1;
      chk($sformatf("stall%0d.out_valid", k), 64'(dout.out_valid), 64'd1);
      chk($sformatf("stall%0d.in_ready", k), 64'(fin.in_ready), 64'd0);
      chk($sformatf("stall%0d.dec_count", k), 64'(dec_count), 64'(exp_cnt));
      check_out($sformatf("stall%0d", k), vecs[0].e);
    end
    @(negedge clk);
    dout.out_ready = 1'b1;
    #1;
    chk("stall.release.in_ready", 64'(fin.in_ready), 64'd1);
    check_out("stall.release", vecs[0].e);
    exp_cnt++;
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("stall.second.out_valid", 64'(dout.out_valid), 64'd1);
    chk("stall.second.dec_count", 64'(dec_count), 64'(exp_cnt));
    check_out("stall.second", vecs[1].e);
    @(negedge clk);
    dout.out_ready = 1'b1;
    exp_cnt++;
    @(negedge clk);
    #1;
    chk("stall.end.out_valid", 64'(dout.out_valid), 64'd0);
    chk("stall.end.dec_count", 64'(dec_count), 64'(exp_cnt));

    // flush while holding, with a simultaneous offer
    drive(1'b1, vecs[2].inst, vecs[2].pc, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, vecs[3].inst, vecs[3].pc, 1'b0, 1'b1);
    #1;
    chk("flush.held", 64'(dout.out_valid), 64'd1);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #1;
    chk("flush.out_valid", 64'(dout.out_valid), 64'd0);
    chk("flush.dec_count", 64'(dec_count), 64'(exp_cnt));
    @(negedge clk);
    #1;
    chk("flush.later.out_valid", 64'(dout.out_valid), 64'd0);
    chk("flush.later.dec_count", 64'(dec_count), 64'(exp_cnt));

    // flush during a drain beat: no count
    drive(1'b1, vecs[4].inst, vecs[4].pc, 1'b1, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("flushdrain.held", 64'(dout.out_valid), 64'd1);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flushdrain.out_valid", 64'(dout.out_valid), 64'd0);
    chk("flushdrain.dec_count", 64'(dec_count), 64'(exp_cnt));

    // reset while stalled
    drive(1'b1, vecs[0].inst, vecs[0].pc, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    #1;
    chk("rststall.held", 64'(dout.out_valid), 64'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rststall.out_valid", 64'(dout.out_valid), 64'd0);
    chk("rststall.dec_count", 64'(dec_count), 64'd0);
    check_out("rststall", '0);
    exp_cnt = '0;

    // 64-bit datapath build
    @(negedge clk);
    fin64.in_valid = 1'b1;
    fin64.inst = 32'h2008_8000;
    fin64.pc_plus4 = 32'h0000_0040;
    @(negedge clk);
    fin64.in_valid = 1'b0;
    #1;
    chk("w64.out_valid", 64'(dout64.out_valid), 64'd1);
    chk("w64.imm", dout64.imm_ext, 64'hFFFF_FFFF_FFFF_8000);
    chk("w64.class", 64'(dout64.inst_class), 64'd1);
    chk("w64.rt", 64'(dout64.rt), 64'd8);
    chk("w64.rs", 64'(dout64.rs), 64'd0);
    chk("w64.bt", 64'(dout64.branch_target), 64'hFFFE_0040);

    // randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      drive(($urandom_range(0, 9) < 7), rand_inst(), $urandom(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
      #1;
      chk("rnd.in_ready", 64'(fin.in_ready), 64'(!dout.out_valid || dout.out_ready));
      chk("rnd.out_valid", 64'(dout.out_valid), 64'(exp_q.size() != 0));
      chk("rnd.dec_count", 64'(dec_count), 64'(exp_cnt));
      if (dout.out_valid && exp_q.size() != 0) check_out("rnd", exp_q[0]);
      if (flush) begin
        exp_q.delete();
      end else begin
        if (dout.out_valid && dout.out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          exp_cnt++;
        end
        if (fin.in_valid && fin.in_ready) exp_q.push_back(ref_decode(fin.inst, fin.pc_plus4));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
